// File: rtl/counter_run_sequencer.sv
// Round-robin scheduler sharing one WIDTH-bit up-counter among NREQ requesters; optional COUNTER_RUN_SEQ_PAUSE_EN adds pause_i.
// Latency: grant 1 cycle after request seen in IDLE, done pulse at cycle 2+len, all outputs registered.
// Backpressure: none; req is a level held until done or abort, pause_i (if built) freezes the running count.
module counter_run_sequencer #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
`ifdef COUNTER_RUN_SEQ_PAUSE_EN
    input  logic                    pause_i,
`endif
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   len_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    busy_o,
    output logic [WIDTH-1:0]        count_o,
    output logic [NREQ-1:0]         done_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, idx_q, idx_d;
    logic [WIDTH-1:0] len_q, len_d, count_q, count_d;
    logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
    logic             busy_q, busy_d;
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic             stall;
    logic [WIDTH-1:0] len_arr [NREQ];

`ifdef COUNTER_RUN_SEQ_PAUSE_EN
    assign stall = pause_i;
`else
    assign stall = 1'b0;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign len_arr[g] = len_i[g*WIDTH +: WIDTH];
    end

    // First requester at or after ptr_q, wrapping around
    always_comb begin
        int      cand;
        logic [IW-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(ptr_q) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!pick_vld && req_i[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (pick_vld) state_d = S_RUN;
            S_RUN: begin
                if (!req_i[idx_q])                       state_d = S_IDLE;
                else if (!stall && count_q == len_q)     state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Abort is checked ahead of pause so a dropped req ends a frozen run
    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        count_d = count_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                gnt_d   = '0;
                busy_d  = 1'b0;
                if (pick_vld) begin
                    idx_d  = pick_idx;
                    len_d  = len_arr[pick_idx];
                    gnt_d  = NREQ'(1) << pick_idx;
                    busy_d = 1'b1;
                    ptr_d  = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                end
            end
            S_RUN: begin
                if (!req_i[idx_q]) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else if (!stall) begin
                    if (count_q == len_q) begin
                        gnt_d  = '0;
                        done_d = NREQ'(1) << idx_q;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                count_d = '0;
                gnt_d   = '0;
            end
            default: begin
                busy_d  = 1'b0;
                count_d = '0;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Directed and randomized checks of counter_run_sequencer against a run-level reference model.
module tb_counter_run_sequencer;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic           pause = 1'b0;
    logic [N-1:0]   gnt, done;
    logic           busy;
    logic [W-1:0]   count;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = no run, 1 = counting, 2 = completion cycle
    int m_phase = 0, m_owner = 0, m_cnt = 0, m_len = 0, m_last = N - 1;

    counter_run_sequencer #(.WIDTH(W), .NREQ(N)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
`ifdef COUNTER_RUN_SEQ_PAUSE_EN
        .pause_i (pause),
`endif
        .req_i   (req),
        .len_i   (len),
        .gnt_o   (gnt),
        .busy_o  (busy),
        .count_o (count),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int req_bit(input int i);
        return int'((req >> i) & 1);
    endfunction

    task automatic model_tick();
        bit found;
        int c;
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_owner = 0; m_last = N - 1;
        end else begin
            case (m_phase)
                0: begin
                    m_cnt = 0;
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (!found && req_bit(c) == 1) begin
                            found = 1'b1;
                            m_owner = c;
                        end
                    end
                    if (found) begin
                        m_len   = int'((len >> (m_owner * W)) & ((1 << W) - 1));
                        m_phase = 1;
                        m_last  = m_owner;
                    end
                end
                1: begin
                    if (req_bit(m_owner) == 0) begin
                        m_phase = 0; m_cnt = 0;
                    end else if (!pause) begin
                        if (m_cnt == m_len) m_phase = 2;
                        else m_cnt = m_cnt + 1;
                    end
                end
                default: begin
                    m_phase = 0; m_cnt = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        check("gnt",   32'(gnt),   (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
        check("done",  32'(done),  (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
        check("busy",  32'(busy),  (m_phase != 0) ? 32'd1 : 32'd0);
        check("count", 32'(count), 32'(m_cnt));
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0; req = '0; len = '0;
        step(); step();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_done", 32'(done), 0);

        // Single run, len0=3
        rst_n = 1'b1; req = 2'b01; len = 8'h03;
        step();
        check("t1_gnt_c1", 32'(gnt), 32'b01);
        check("t1_cnt_c1", 32'(count), 0);
        step(); step(); step();
        check("t1_cnt_c4", 32'(count), 3);
        step();
        check("t1_done_c5", 32'(done), 32'b01);
        check("t1_gnt_c5", 32'(gnt), 0);
        req = 2'b00;
        step();
        check("t1_busy_c6", 32'(busy), 0);

        // Simultaneous requests from reset
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 2'b11; len = 8'h12;
        step();
        check("t2_gnt_c1", 32'(gnt), 32'b01);
        step(); step(); step();
        check("t2_done_c4", 32'(done), 32'b01);
        req = 2'b10;
        step();
        step();
        check("t2_gnt_c6", 32'(gnt), 32'b10);
        step();
        check("t2_cnt_c7", 32'(count), 1);
        step();
        check("t2_done_c8", 32'(done), 32'b10);
        req = 2'b00;
        step();

        // Zero length run
        req = 2'b01; len = 8'h00;
        step();
        check("t3_gnt_c1", 32'(gnt), 32'b01);
        step();
        check("t3_done_c2", 32'(done), 32'b01);
        req = 2'b00;
        step();

        // Abort mid-run
        req = 2'b01; len = 8'h05;
        step(); step(); step();
        check("t4_cnt_c3", 32'(count), 2);
        req = 2'b00;
        step();
        check("t4_gnt_abort", 32'(gnt), 0);
        check("t4_busy_abort", 32'(busy), 0);
        check("t4_done_abort", 32'(done), 0);

        // Reset mid-run
        req = 2'b01; len = 8'h0F;
        for (int i = 0; i < 8; i++) step();
        check("t5_cnt_c8", 32'(count), 7);
        rst_n = 1'b0; req = 2'b11;
        step();
        check("t5_rst_gnt", 32'(gnt), 0);
        check("t5_rst_cnt", 32'(count), 0);
        rst_n = 1'b1; req = 2'b10; len = 8'h00;
        step();
        check("t5_req1_gnt", 32'(gnt), 32'b10);
        step();
        req = 2'b00;
        step();

        // Maximum length reaches all-ones without wrapping
        req = 2'b01; len = 8'h0F;
        for (int i = 0; i < 16; i++) step();
        check("max_cnt_c16", 32'(count), 15);
        step();
        check("max_done_c17", 32'(done), 32'b01);
        check("max_cnt_c17", 32'(count), 15);
        req = 2'b00;
        step();

`ifdef COUNTER_RUN_SEQ_PAUSE_EN
        // Three frozen edges move done from c6 to c9
        req = 2'b01; len = 8'h04;
        step(); step(); step();
        pause = 1'b1;
        step(); step(); step();
        check("t6_cnt_paused", 32'(count), 2);
        pause = 1'b0;
        step(); step(); step();
        check("t6_done_c9", 32'(done), 32'b01);
        req = 2'b00;
        step();
`endif

        // Randomized traffic; a requester drops req after its done pulse
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            len   = N*W'($urandom);
            for (int i = 0; i < N; i++) begin
                if (m_phase == 2 && m_owner == i)
                    req = req & ~N'(1 << i);
                else if (req_bit(i) == 0) begin
                    if ($urandom_range(0, 3) == 0) req = req | N'(1 << i);
                end else if ($urandom_range(0, 49) == 0)
                    req = req & ~N'(1 << i);
            end
`ifdef COUNTER_RUN_SEQ_PAUSE_EN
            pause = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
